hilo_muldiv_unit: RTL
=====================

# hilo_muldiv_unit

Parametrised multicycle multiply/divide unit owning the HI/LO register pair, sitting in the Execute stage beside the single-cycle ALU. Accepts one HILO-class operation at a time and runs multiplies through a configurable-latency multiplier and divides through an iterative radix-2 divider. It requests a pipeline stall only when a later instruction touches HI/LO while an operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; minimum 8.
- MUL_LATENCY, 3, busy cycles for the multiply family; minimum 1.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; one clock, reset is synchronous and active-low.
- EX_Stall  in  1  Execute stage stalled; no op is accepted.
- EX_Flush  in  1  Execute-stage instruction squashed; no op is accepted.
- Op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 DIV, 8 DIVU, 9 MTHI, 10 MTLO, 11 MFHI, 12 MFLO; 13–15 behave as NOP.
- A, B  in  WIDTH  operands; rs and rt respectively.
- HI, LO  out  WIDTH  current HI/LO register contents.
- Busy  out  1  multiply or divide in flight.
- HiLo_Stall  out  1  stall request to the pipeline.

## Operation
- HILO ops are Op 1–12. HiLo_Stall = Busy & (Op is a HILO op); it is combinational.
- An op is accepted when it is a HILO op and EX_Stall=0, EX_Flush=0 and Busy=0.
- MTHI writes HI←A. MTLO writes LO←B. Both write at the accepting edge.
- MFHI/MFLO write nothing. The pipeline reads HI/LO directly; they only need HiLo_Stall.
- Multiply family:
  - Operands are captured at acceptance; the 2·WIDTH product is signed for MULT/MADD/MSUB and unsigned for the U forms.
  - {HI,LO} ← product; ← {HI,LO}+product; or ← {HI,LO}−product.
  - Accumulation is mod 2^(2·WIDTH).
  - For MADD/MSUB, the {HI,LO} value used is the one present at the commit edge.
- Divide family:
  - Restoring radix-2, one quotient bit per cycle, on the operand magnitudes.
  - For DIV, the quotient is negated if the operand signs differ, and the remainder takes the sign of A.
  - Result: LO←quotient, HI←remainder.
  - Divide by zero: LO=all ones, HI=A (sign fixup skipped).
  - DIV of most-negative ÷ −1: LO=most-negative, HI=0.
- States: IDLE, MUL, DIV.
  - IDLE→MUL or IDLE→DIV on acceptance.
  - MUL/DIV→IDLE at the commit edge, which is the last busy cycle.
- Non-HILO ops never stall and are ignored.
- EX_Stall and EX_Flush do not affect an in-flight op; it always commits.
- RST_N=0 at any time: state→IDLE, HI=LO=0, Busy=0, and any in-flight op is discarded with no later write.

## Timing
- Reset values: HI=0, LO=0, Busy=0; HiLo_Stall=0 provided Op=NOP.
- Accept at edge t. Busy is high for cycles t+1 … t+N and {HI,LO} is written at the edge ending cycle t+N.
  - N=MUL_LATENCY for the multiply family; N=WIDTH for the divide family.
  - Busy is low in cycle t+N+1, and the new HI/LO is visible that cycle.
- A HILO op presented during busy cycles stalls and is accepted at the edge ending cycle t+N+1. Back-to-back HILO ops therefore have a one-idle-cycle gap.
- MTHI/MTLO take zero busy cycles; the new value is visible the cycle after the accepting edge.

## Configuration
- MULDIV_MADD_EN defined: MADD, MADDU, MSUB and MSUBU are implemented as above, including the accumulator adder/subtractor.
- Not defined: Op 3–6 behave as NOP, with no HILO write, no Busy and no HiLo_Stall. The accumulate datapath is absent.

## Test plan
(WIDTH=32, MUL_LATENCY=3)
- MULT A=0xFFFFFFFD (−3), B=7 → Busy high for 3 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (−7), B=2, then MFLO on the next cycle → HiLo_Stall high for 32 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF, and MFLO accepted at the next edge.
- DIVU A=0x00001234, B=0 → after 32 cycles LO=0xFFFFFFFF, HI=0x00001234.
- MADDU with {HI,LO}=0x00000000_FFFFFFFF, A=1, B=1 → {HI,LO}=0x00000001_00000000. With MULDIV_MADD_EN undefined → unchanged, Busy=0.
- RST_N low for 1 cycle at busy cycle 10 of a DIV → next cycle Busy=0, HI=LO=0; no write afterwards.
- MTHI A=5 with EX_Stall=1 for 2 cycles, then 0 → HI unchanged while stalled, HI=5 one cycle after release. The same op with EX_Flush=1 → no write.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: multicycle multiplier and restoring radix-2 divider.
// Optional MADD/MADDU/MSUB/MSUBU accumulate support is enabled with `define MULDIV_MADD_EN.
module hilo_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EX_Stall,
    input  logic             EX_Flush,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             HiLo_Stall
);

    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [3:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
        OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e          state;
    logic [CW-1:0]   cnt;

    logic            is_mul, is_div, is_move, is_hilo, accept;
    logic            mul_sgn, div_sgn;
`ifdef MULDIV_MADD_EN
    logic            acc_add, acc_sub;
    logic            acc_add_q, acc_sub_q;
`endif

    logic [2*WIDTH-1:0] mul_a, mul_b, product, mul_res, div_res;
    logic [WIDTH-1:0]   div_rem, div_quo, div_den, div_a;
    logic               div_zero, neg_q, neg_r;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_nxt, quo_nxt;
    logic [WIDTH:0]     partial, trial;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_move = 1'b0;
        mul_sgn = 1'b0;
        div_sgn = 1'b0;
`ifdef MULDIV_MADD_EN
        acc_add = 1'b0;
        acc_sub = 1'b0;
`endif
        case (Op)
            OP_MULT:  begin is_mul = 1'b1; mul_sgn = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; mul_sgn = 1'b1; acc_add = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; acc_add = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; mul_sgn = 1'b1; acc_sub = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; acc_sub = 1'b1; end
`endif
            OP_DIV:   begin is_div = 1'b1; div_sgn = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: is_move = 1'b1;
            default: ;
        endcase
    end

    assign is_hilo    = is_mul | is_div | is_move;
    assign Busy       = (state != S_IDLE);
    assign HiLo_Stall = Busy & is_hilo;
    assign accept     = is_hilo & ~EX_Stall & ~EX_Flush & ~Busy;

    assign a_neg = div_sgn & A[WIDTH-1];
    assign b_neg = div_sgn & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // One restoring step; the last step feeds the commit directly.
    assign partial = {div_rem, div_quo[WIDTH-1]};
    assign trial   = partial - {1'b0, div_den};

    always_comb begin
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {div_quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = partial[WIDTH-1:0];
            quo_nxt = {div_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        if (div_zero)
            div_res = {div_a, {WIDTH{1'b1}}};
        else
            div_res = {neg_r ? -rem_nxt : rem_nxt, neg_q ? -quo_nxt : quo_nxt};
    end

    assign product = mul_a * mul_b;

    always_comb begin
        mul_res = product;
`ifdef MULDIV_MADD_EN
        if (acc_add_q)
            mul_res = {HI, LO} + product;
        else if (acc_sub_q)
            mul_res = {HI, LO} - product;
`endif
    end

    // NOTE: operand/iteration registers carry no reset; they are only read while the FSM is busy.
    always_ff @(posedge CLK) begin
        if (accept && is_mul) begin
            mul_a <= {{WIDTH{mul_sgn & A[WIDTH-1]}}, A};
            mul_b <= {{WIDTH{mul_sgn & B[WIDTH-1]}}, B};
`ifdef MULDIV_MADD_EN
            acc_add_q <= acc_add;
            acc_sub_q <= acc_sub;
`endif
        end
        if (accept && is_div) begin
            div_rem  <= '0;
            div_quo  <= a_mag;
            div_den  <= b_mag;
            div_a    <= A;
            div_zero <= (B == '0);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
        end else if (state == S_DIV) begin
            div_rem <= rem_nxt;
            div_quo <= quo_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= S_MUL;
                            cnt   <= CW'(MUL_LATENCY - 1);
                        end else if (is_div) begin
                            state <= S_DIV;
                            cnt   <= CW'(WIDTH - 1);
                        end else if (Op == OP_MTHI) begin
                            HI <= A;
                        end else if (Op == OP_MTLO) begin
                            LO <= B;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        {HI, LO} <= mul_res;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        {HI, LO} <= div_res;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
